// File: rtl/cheshire_launch_ctrl.sv
// cheshire_launch_ctrl
//
// Hardware launch sequencer for Cheshire. On an accepted start pulse it writes
// the 64-bit entry point into the boot registers (low word, then high word),
// writes 1 to the GO register, and then polls the end-of-computation (EOC)
// scratch register every PollInterval cycles until bit 0 reads back as 1. The
// remaining 31 bits of that EOC value are reported as the exit code.
//
// Optional feature macro: CHESHIRE_LAUNCH_TIMEOUT_EN
//   Defined   : EOC reads with bit0=0 are counted; reaching MaxPolls ends in
//               ERR with timeout_o=1 (MaxPolls=0 disables the limit).
//   Undefined : polling continues indefinitely and timeout_o is tied to 0.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, entry_i    launch pulse and entry point (sampled in IDLE/DONE/ERR)
//   busy_o              sequence in progress
//   done_o, exit_code_o EOC seen, with EOC value >> 1
//   error_o, timeout_o  bus error or poll timeout, and timeout cause flag
//   req_*               register-bus request (valid/ready, write, addr, wdata)
//   rsp_*               register-bus response (valid, rdata, error)

module cheshire_launch_ctrl #(
  parameter int unsigned AddrWidth    = 64,
  parameter logic [63:0] EntryAddr    = 64'h0000_0000_0200_4010,
  parameter logic [63:0] GoAddr       = 64'h0000_0000_0200_4018,
  parameter logic [63:0] EocAddr      = 64'h0000_0000_0200_4004,
  parameter int unsigned PollInterval = 16,
  parameter int unsigned MaxPolls     = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [63:0]          entry_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 timeout_o,
  output logic [30:0]          exit_code_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 req_write_o,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [31:0]          req_wdata_o,
  input  logic                 rsp_valid_i,
  input  logic [31:0]          rsp_rdata_i,
  input  logic                 rsp_error_i
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_LO     = 3'd1;
  localparam logic [2:0] S_WR_HI     = 3'd2;
  localparam logic [2:0] S_WR_GO     = 3'd3;
  localparam logic [2:0] S_POLL_WAIT = 3'd4;
  localparam logic [2:0] S_RD_EOC    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  localparam logic [63:0] EntryHiAddr = EntryAddr + 64'd4;

  localparam logic [AddrWidth-1:0] AddrLo  = EntryAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] AddrHi  = EntryHiAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] AddrGo  = GoAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] AddrEoc = EocAddr[AddrWidth-1:0];

  // Interval counter runs 0..PollInterval-1 while in POLL_WAIT.
  localparam int unsigned     PW       = (PollInterval > 1) ? $clog2(PollInterval) : 1;
  localparam logic [PW-1:0]   WaitLast = PW'(PollInterval - 1);

  logic [2:0]    state_q, state_d;
  logic          pend_q, pend_d;      // request accepted, awaiting response
  logic [63:0]   entry_q, entry_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [30:0]   exit_q, exit_d;
  logic [PW-1:0] wait_q, wait_d;

`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
  logic          timeout_q, timeout_d;
  logic [31:0]   polls_q, polls_d;
`endif

  logic in_xfer;
  logic idle_like;

  assign in_xfer   = (state_q == S_WR_LO) || (state_q == S_WR_HI) ||
                     (state_q == S_WR_GO) || (state_q == S_RD_EOC);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    entry_d = entry_q;
    done_d  = done_q;
    error_d = error_q;
    exit_d  = exit_q;
    wait_d  = wait_q;
`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
    timeout_d = timeout_q;
    polls_d   = polls_q;
`endif

    if (idle_like) begin
      if (start_i) begin
        entry_d = entry_i;
        done_d  = 1'b0;
        error_d = 1'b0;
        pend_d  = 1'b0;
        state_d = S_WR_LO;
`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
        timeout_d = 1'b0;
        polls_d   = '0;
`endif
      end
    end else if (state_q == S_POLL_WAIT) begin
      if (wait_q == WaitLast) begin
        state_d = S_RD_EOC;
        pend_d  = 1'b0;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else if (in_xfer) begin
      if (!pend_q) begin
        if (req_ready_i) pend_d = 1'b1;
      end else if (rsp_valid_i) begin
        pend_d = 1'b0;
        if (rsp_error_i) begin
          state_d = S_ERR;
          error_d = 1'b1;
`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else begin
          case (state_q)
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: state_d = S_WR_GO;
            S_WR_GO: begin
              state_d = S_POLL_WAIT;
              wait_d  = '0;
            end
            default: begin
              if (rsp_rdata_i[0]) begin
                exit_d  = rsp_rdata_i[31:1];
                done_d  = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_POLL_WAIT;
                wait_d  = '0;
`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
                polls_d = polls_q + 32'd1;
                if ((MaxPolls != 0) && (polls_d == MaxPolls)) begin
                  state_d   = S_ERR;
                  error_d   = 1'b1;
                  timeout_d = 1'b1;
                end
`endif
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      entry_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      exit_q  <= '0;
      wait_q  <= '0;
`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
      timeout_q <= 1'b0;
      polls_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      entry_q <= entry_d;
      done_q  <= done_d;
      error_q <= error_d;
      exit_q  <= exit_d;
      wait_q  <= wait_d;
`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
      timeout_q <= timeout_d;
      polls_q   <= polls_d;
`endif
    end
  end

  // Request fields derive only from state and latched entry, so they cannot
  // change while a request is being held off by req_ready_i.
  always_comb begin
    req_addr_o  = '0;
    req_wdata_o = '0;
    case (state_q)
      S_WR_LO: begin
        req_addr_o  = AddrLo;
        req_wdata_o = entry_q[31:0];
      end
      S_WR_HI: begin
        req_addr_o  = AddrHi;
        req_wdata_o = entry_q[63:32];
      end
      S_WR_GO: begin
        req_addr_o  = AddrGo;
        req_wdata_o = 32'h1;
      end
      S_RD_EOC: req_addr_o = AddrEoc;
      default: ;
    endcase
  end

  assign req_valid_o = in_xfer && !pend_q;
  assign req_write_o = in_xfer && (state_q != S_RD_EOC);
  assign busy_o      = !idle_like;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign exit_code_o = exit_q;

`ifdef CHESHIRE_LAUNCH_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
